// File: rtl/box_stream_ctrl.sv
// Frame sequencer for the box-filter sample path: buffers a source frame in a FIFO,
// clears the accumulator, issues the samples, then appends wl-1 zero flush samples.
module box_stream_ctrl #(
   parameter int DATA_W  = 22,
   parameter int DEPTH   = 8,
   parameter int WIN_MAX = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [4:0]               win_len,
   input  logic [31:0]              frame_len,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic                     dp_valid,
   output logic signed [DATA_W-1:0] dp_data,
   input  logic                     dp_ready,
   output logic                     dp_clear,
   output logic                     dp_flush,
   output logic                     busy,
   output logic                     done,
   output logic [31:0]              sample_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [4:0]    wl_q, wl_d;
   logic [31:0]   frame_len_q, frame_len_d;
   logic [31:0]   acc_cnt_q, acc_cnt_d;
   logic [31:0]   sample_cnt_q, sample_cnt_d;
   logic [4:0]    flush_cnt_q, flush_cnt_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic signed [DATA_W-1:0] mem_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic mem_we;

   // Window length 0 behaves as 1; anything beyond the largest window saturates.
   function automatic logic [4:0] clamp_win(input logic [4:0] w);
      if (w == 5'd0) begin
         return 5'd1;
      end else if (int'(w) > WIN_MAX) begin
         return 5'(WIN_MAX);
      end else begin
         return w;
      end
   endfunction

   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

   assign in_ready   = (state_q == S_RUN) && !full && (acc_cnt_q < frame_len_q);
   assign dp_valid   = ((state_q == S_RUN) && !empty) || (state_q == S_FLUSH);
   assign dp_data    = ((state_q == S_RUN) && !empty) ? mem_q[rd_ptr_q] : '0;
   assign dp_clear   = (state_q == S_CLEAR);
   assign dp_flush   = (state_q == S_FLUSH);
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign sample_cnt = sample_cnt_q;

   assign push   = in_valid && in_ready;
   assign pop    = (state_q == S_RUN) && !empty && dp_ready;
   assign mem_we = push && !abort;

   always_comb begin
      state_d      = state_q;
      wl_d         = wl_q;
      frame_len_d  = frame_len_q;
      acc_cnt_d    = acc_cnt_q;
      sample_cnt_d = sample_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               wl_d         = clamp_win(win_len);
               frame_len_d  = frame_len;
               acc_cnt_d    = '0;
               sample_cnt_d = '0;
               flush_cnt_d  = '0;
               wr_ptr_d     = '0;
               rd_ptr_d     = '0;
               count_d      = '0;
               state_d      = (frame_len == 32'd0) ? S_DONE : S_CLEAR;
            end
         end
         S_CLEAR: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (push) begin
               wr_ptr_d  = wr_ptr_q + 1'b1;
               acc_cnt_d = acc_cnt_q + 32'd1;
            end
            if (pop) begin
               rd_ptr_d     = rd_ptr_q + 1'b1;
               sample_cnt_d = sample_cnt_q + 32'd1;
               if ((sample_cnt_q + 32'd1) == frame_len_q) begin
                  flush_cnt_d = '0;
                  state_d     = (wl_q > 5'd1) ? S_FLUSH : S_DONE;
               end
            end
            case ({push, pop})
               2'b10:   count_d = count_q + 1'b1;
               2'b01:   count_d = count_q - 1'b1;
               default: count_d = count_q;
            endcase
         end
         S_FLUSH: begin
            if (dp_ready) begin
               if ((flush_cnt_q + 5'd1) == (wl_q - 5'd1)) begin
                  state_d = S_DONE;
               end else begin
                  flush_cnt_d = flush_cnt_q + 5'd1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort drops the frame without a done pulse; the issued-sample count is kept.
      if (abort && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         count_d      = '0;
         acc_cnt_d    = acc_cnt_q;
         sample_cnt_d = sample_cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wl_q         <= 5'd1;
         frame_len_q  <= '0;
         acc_cnt_q    <= '0;
         sample_cnt_q <= '0;
         flush_cnt_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         wl_q         <= wl_d;
         frame_len_q  <= frame_len_d;
         acc_cnt_q    <= acc_cnt_d;
         sample_cnt_q <= sample_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Sample storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: tb/tb_box_stream_ctrl.sv
// Directed bench for box_stream_ctrl: drives frames through the controller and
// compares issued samples, flush zeros and control pulses against hand-derived values.
module tb_box_stream_ctrl;

   localparam int DATA_W = 22;

   logic                     clk;
   logic                     rst;
   logic                     start;
   logic                     abort;
   logic [4:0]               win_len;
   logic [31:0]              frame_len;
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_ready;
   logic                     dp_valid;
   logic signed [DATA_W-1:0] dp_data;
   logic                     dp_ready;
   logic                     dp_clear;
   logic                     dp_flush;
   logic                     busy;
   logic                     done;
   logic [31:0]              sample_cnt;

   box_stream_ctrl #(.DATA_W(DATA_W), .DEPTH(8), .WIN_MAX(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .win_len    (win_len),
      .frame_len  (frame_len),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .dp_valid   (dp_valid),
      .dp_data    (dp_data),
      .dp_ready   (dp_ready),
      .dp_clear   (dp_clear),
      .dp_flush   (dp_flush),
      .busy       (busy),
      .done       (done),
      .sample_cnt (sample_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic signed [DATA_W-1:0] src_q[$];
   logic signed [DATA_W-1:0] out_q[$];
   logic                     flg_q[$];
   int   src_idx;
   int   acc;
   int   clr_cnt;
   int   clr_cyc;
   int   done_cnt;
   int   done_cyc;
   int   acc_at_stall;
   logic inr_at_stall;
   logic rej_seen;
   logic timed_out;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame cycle by cycle from the CLEAR cycle until done (or abort).
   task automatic pump(input int max_cyc, input int stall, input int abort_at);
      logic fin;
      src_idx = 0; acc = 0; clr_cnt = 0; clr_cyc = -1; done_cnt = 0; done_cyc = -1;
      acc_at_stall = -1; inr_at_stall = 1'bx; rej_seen = 1'b0; timed_out = 1'b0;
      out_q.delete();
      flg_q.delete();
      for (int cyc = 0; cyc < max_cyc; cyc++) begin
         dp_ready = (cyc >= stall);
         in_valid = (src_idx < src_q.size());
         in_data  = in_valid ? src_q[src_idx] : '0;
         abort    = (cyc == abort_at);
         #1;
         if (dp_clear) begin clr_cnt++; clr_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (cyc == stall - 1) begin acc_at_stall = acc; inr_at_stall = in_ready; end
         if (in_valid && !in_ready && src_idx == 3) rej_seen = 1'b1;
         if (in_valid && in_ready) begin acc++; src_idx++; end
         if (dp_valid && dp_ready) begin out_q.push_back(dp_data); flg_q.push_back(dp_flush); end
         fin = done || abort;
         tick();
         if (fin) begin
            abort = 1'b0; in_valid = 1'b0; dp_ready = 1'b0;
            return;
         end
      end
      timed_out = 1'b1;
      abort = 1'b0; in_valid = 1'b0; dp_ready = 1'b0;
   endtask

   task automatic begin_frame(input logic [31:0] fl, input logic [4:0] wl);
      start = 1'b1; frame_len = fl; win_len = wl;
      tick();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [DATA_W-1:0] exp_a [8];
      exp_a = '{22'sd100, -22'sd1, 22'sd2097151, -22'sd2097152, 22'sd7, 22'sd0, 22'sd0, 22'sd0};

      rst = 1'b1; start = 1'b0; abort = 1'b0; win_len = '0; frame_len = '0;
      in_valid = 1'b0; in_data = '0; dp_ready = 1'b0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_dp_valid", dp_valid, 0);
      chk("rst_dp_data", dp_data, 0);
      chk("rst_dp_clear", dp_clear, 0);
      chk("rst_dp_flush", dp_flush, 0);
      chk("rst_done", done, 0);
      chk("rst_sample_cnt", sample_cnt, 0);
      tick();
      rst = 1'b0;
      tick();

      // Frame of 5 with window 4; later changes to frame_len/win_len must not matter.
      src_q = '{22'sd100, -22'sd1, 22'sd2097151, -22'sd2097152, 22'sd7};
      begin_frame(32'd5, 5'd4);
      frame_len = 32'd99; win_len = 5'd1;
      pump(60, 0, -1);
      chk("a_timeout", timed_out, 0);
      chk("a_clear_cnt", clr_cnt, 1);
      chk("a_clear_cyc", clr_cyc, 0);
      chk("a_out_len", out_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < out_q.size()) begin
            chk($sformatf("a_data%0d", i), out_q[i], exp_a[i]);
            chk($sformatf("a_flush%0d", i), flg_q[i], (i >= 5) ? 1 : 0);
         end
      end
      chk("a_done_cnt", done_cnt, 1);
      chk("a_done_cyc", done_cyc, 10);
      chk("a_sample_cnt", sample_cnt, 5);
      chk("a_idle_busy", busy, 0);

      // Backpressure: 20 samples, sink stalled for the first 15 cycles.
      src_q.delete();
      for (int i = 0; i < 20; i++) src_q.push_back(DATA_W'(i * 1000 - 7000));
      begin_frame(32'd20, 5'd1);
      pump(200, 15, -1);
      chk("b_timeout", timed_out, 0);
      chk("b_acc_stalled", acc_at_stall, 8);
      chk("b_in_ready_full", inr_at_stall, 0);
      chk("b_out_len", out_q.size(), 20);
      for (int i = 0; i < 20; i++) begin
         if (i < out_q.size()) begin
            chk($sformatf("b_data%0d", i), out_q[i], i * 1000 - 7000);
            chk($sformatf("b_flush%0d", i), flg_q[i], 0);
         end
      end
      chk("b_done_cnt", done_cnt, 1);
      chk("b_sample_cnt", sample_cnt, 20);

      // Over-offering source, window 0 treated as 1.
      src_q = '{22'sd31, -22'sd32, 22'sd33, 22'sd34, 22'sd35, 22'sd36};
      begin_frame(32'd3, 5'd0);
      pump(60, 0, -1);
      chk("c_timeout", timed_out, 0);
      chk("c_accepted", acc, 3);
      chk("c_rejected_4th", rej_seen, 1);
      chk("c_out_len", out_q.size(), 3);
      if (out_q.size() == 3) begin
         chk("c_data0", out_q[0], 31);
         chk("c_data1", out_q[1], -32);
         chk("c_data2", out_q[2], 33);
      end
      chk("c_done_cyc", done_cyc, 5);
      chk("c_sample_cnt", sample_cnt, 3);

      // Empty frame; start held high through DONE must be ignored.
      start = 1'b1; frame_len = 32'd0; win_len = 5'd4;
      tick();
      chk("d_done", done, 1);
      chk("d_busy", busy, 1);
      chk("d_no_clear", dp_clear, 0);
      chk("d_no_valid", dp_valid, 0);
      chk("d_sample_cnt", sample_cnt, 0);
      tick();
      start = 1'b0;
      chk("d_idle_done", done, 0);
      chk("d_idle_busy", busy, 0);
      tick();
      chk("d_not_restarted", busy, 0);

      // Abort on the second flush zero, then a normal frame.
      src_q = '{22'sd11, -22'sd22};
      begin_frame(32'd2, 5'd4);
      pump(60, 0, 5);
      chk("e_timeout", timed_out, 0);
      chk("e_busy", busy, 0);
      chk("e_dp_valid", dp_valid, 0);
      chk("e_in_ready", in_ready, 0);
      chk("e_dp_flush", dp_flush, 0);
      chk("e_done_now", done, 0);
      chk("e_done_cnt", done_cnt, 0);
      chk("e_sample_cnt", sample_cnt, 2);
      chk("e_out_len", out_q.size(), 4);
      tick();
      chk("e_no_late_done", done, 0);
      chk("e_sample_hold", sample_cnt, 2);
      src_q = '{22'sd5, 22'sd6};
      begin_frame(32'd2, 5'd2);
      pump(60, 0, -1);
      chk("e2_timeout", timed_out, 0);
      chk("e2_out_len", out_q.size(), 3);
      if (out_q.size() == 3) begin
         chk("e2_data0", out_q[0], 5);
         chk("e2_data1", out_q[1], 6);
         chk("e2_data2", out_q[2], 0);
         chk("e2_flush2", flg_q[2], 1);
      end
      chk("e2_done_cnt", done_cnt, 1);
      chk("e2_done_cyc", done_cyc, 5);
      chk("e2_sample_cnt", sample_cnt, 2);

      // Asynchronous reset with three samples buffered.
      begin_frame(32'd10, 5'd1);
      tick();
      dp_ready = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = DATA_W'(200 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("f_buffered_valid", dp_valid, 1);
      chk("f_buffered_head", dp_data, 200);
      #3;
      rst = 1'b1;
      #1;
      chk("f_rst_busy", busy, 0);
      chk("f_rst_dp_valid", dp_valid, 0);
      chk("f_rst_dp_data", dp_data, 0);
      chk("f_rst_in_ready", in_ready, 0);
      chk("f_rst_sample_cnt", sample_cnt, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("f_post_busy", busy, 0);
      chk("f_post_dp_valid", dp_valid, 0);
      src_q = '{22'sd42};
      begin_frame(32'd1, 5'd1);
      pump(30, 0, -1);
      chk("f_min_timeout", timed_out, 0);
      chk("f_min_out_len", out_q.size(), 1);
      if (out_q.size() == 1) chk("f_min_data", out_q[0], 42);
      chk("f_min_done_cyc", done_cyc, 3);
      chk("f_min_sample_cnt", sample_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
